// File: rtl/fp_mul_seq_ctrl.sv
// Sequential FP32 multiplier controller: shift-add mantissa multiply,
// then normalize, denormalize, round-to-nearest-even and flag generation.
module fp_mul_seq_ctrl #(
    parameter int MUL_STEPS = 24,
    parameter int BIAS      = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        invalid_flag,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic               sign_r;
    logic [7:0]         ex_r, ey_r;
    logic [23:0]        ma_r;
    logic [47:0]        prod_r;
    logic [4:0]         cnt_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mant_r;
    logic               guard_r, sticky_r, tiny_r;
    logic [31:0]        z_r;
    logic               ovf_r, unf_r, inv_r;

    logic accept;
    assign accept = in_valid & in_ready;

    // Operand classification for the fast path; denormals count as zero
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic sign_in, spec_hit, spec_inv;
    logic [31:0] spec_z;

    always_comb begin
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        b_zero = (b[30:23] == 8'h00);
        sign_in  = a[31] ^ b[31];
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_z   = {sign_in, 31'd0};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_z   = 32'h7FC0_0000;
            spec_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_z = {sign_in, 8'hFF, 23'd0};
        end else if (!(a_zero || b_zero)) begin
            spec_hit = 1'b0;
        end
    end

    // One radix-2 step: multiplier bit sits in prod_r[0], shifted out each cycle
    logic [24:0] mul_sum;
    logic [47:0] prod_nxt;

    always_comb begin
        mul_sum  = {1'b0, prod_r[47:24]} + (prod_r[0] ? {1'b0, ma_r} : 25'd0);
        prod_nxt = {mul_sum, prod_r[23:1]};
    end

    logic signed [9:0] e_sum, e_norm;
    logic [9:0]  sh_full;
    logic [4:0]  sh;
    logic [23:0] mant_n;
    logic        g_n, s_n, tiny_n;
    logic [50:0] wide;
    logic [23:0] mant_d;
    logic        g_d, s_d;

    always_comb begin
        e_sum  = $signed({2'b00, ex_r}) + $signed({2'b00, ey_r})
               - $signed(10'(BIAS));
        e_norm = e_sum + (prod_r[47] ? 10'sd1 : 10'sd0);
        if (prod_r[47]) begin
            mant_n = prod_r[47:24];
            g_n    = prod_r[23];
            s_n    = |prod_r[22:0];
        end else begin
            mant_n = prod_r[46:23];
            g_n    = prod_r[22];
            s_n    = |prod_r[21:0];
        end
        tiny_n  = (e_norm <= 10'sd0);
        sh_full = 10'sd1 - e_norm;
        sh      = (sh_full > 10'd26) ? 5'd26 : sh_full[4:0];
        wide    = {mant_n, g_n, 26'd0} >> sh;
        mant_d  = wide[50:27];
        g_d     = wide[26];
        s_d     = s_n | (|wide[25:0]);
    end

    logic        rnd_inc;
    logic [24:0] rsum;
    logic signed [9:0] e_rnd;
    logic [23:0] m_rnd;
    logic        ovf_n, unf_n;
    logic [31:0] rnd_z;

    always_comb begin
        rnd_inc = guard_r & (sticky_r | mant_r[0]);
        rsum    = {1'b0, mant_r} + {24'd0, rnd_inc};
        e_rnd   = exp_r;
        m_rnd   = rsum[23:0];
        if (rsum[24]) begin
            e_rnd = exp_r + 10'sd1;
            m_rnd = 24'h80_0000;
        end else if ((exp_r == 10'sd0) && rsum[23]) begin
            e_rnd = 10'sd1;
        end
        ovf_n = (e_rnd >= 10'sd255);
        unf_n = tiny_r & ~ovf_n
              & (guard_r | sticky_r | (m_rnd == 24'd0));
        rnd_z = ovf_n ? {sign_r, 8'hFF, 23'd0}
                      : {sign_r, e_rnd[7:0], m_rnd[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = spec_hit ? DONE : MUL;
            MUL:   if (cnt_r == 5'(MUL_STEPS - 1)) state_nxt = NORM;
            NORM:  state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r   <= 1'b0;
            ex_r     <= '0;
            ey_r     <= '0;
            ma_r     <= '0;
            prod_r   <= '0;
            cnt_r    <= '0;
            exp_r    <= '0;
            mant_r   <= '0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            tiny_r   <= 1'b0;
            z_r      <= '0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inv_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign_r <= sign_in;
                    ex_r   <= a[30:23];
                    ey_r   <= b[30:23];
                    ma_r   <= {1'b1, a[22:0]};
                    prod_r <= {24'd0, 1'b1, b[22:0]};
                    cnt_r  <= '0;
                    if (spec_hit) begin
                        z_r   <= spec_z;
                        inv_r <= spec_inv;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                    end
                end
                MUL: begin
                    prod_r <= prod_nxt;
                    cnt_r  <= cnt_r + 5'd1;
                end
                NORM: begin
                    tiny_r <= tiny_n;
                    if (tiny_n) begin
                        exp_r    <= '0;
                        mant_r   <= mant_d;
                        guard_r  <= g_d;
                        sticky_r <= s_d;
                    end else begin
                        exp_r    <= e_norm;
                        mant_r   <= mant_n;
                        guard_r  <= g_n;
                        sticky_r <= s_n;
                    end
                end
                ROUND: begin
                    z_r   <= rnd_z;
                    ovf_r <= ovf_n;
                    unf_r <= unf_n;
                    inv_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign busy           = (state != IDLE);
    assign z              = z_r;
    assign overflow_flag  = ovf_r;
    assign underflow_flag = unf_r;
    assign invalid_flag   = inv_r;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Bench for fp_mul_seq_ctrl: directed plan vectors plus random operands
// checked against an exact-integer round-to-nearest-even product model.
module tb_fp_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        overflow_flag, underflow_flag, invalid_flag;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_mul_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .z              (z),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag),
        .invalid_flag   (invalid_flag),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, rounded RNE at the target quantum
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rz, output logic ro,
                                    output logic ru, output logic ri,
                                    output bit sp);
        int ex, ey, k, e, ee, r, field;
        bit s, xn, xi, xz, yn, yi, yz, up, inexact;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        xz = (ex == 0);
        yn = (ey == 255) && (y[22:0] != 0);
        yi = (ey == 255) && (y[22:0] == 0);
        yz = (ey == 0);
        ro = 0; ru = 0; ri = 0; sp = 1;
        rz = 32'd0;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            rz = 32'h7FC0_0000;
            ri = 1;
        end else if (xi || yi) begin
            rz = {s, 8'hFF, 23'd0};
        end else if (xz || yz) begin
            rz = {s, 31'd0};
        end else begin
            sp = 0;
            p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
            k  = p[47] ? 47 : 46;
            e  = ex + ey - 127 + (k - 46);
            ee = (e < 1) ? 1 : e;
            r  = ee + 150 - ex - ey;
            if (r >= 49) begin
                q = 0;
                up = 0;
                inexact = 1;
            end else begin
                q    = p >> r;
                rem  = p & ((64'd1 << r) - 1);
                half = 64'd1 << (r - 1);
                up   = (rem > half) || ((rem == half) && q[0]);
                inexact = (rem != 0);
            end
            q = q + 64'(up);
            if (q == (64'd1 << 24)) begin
                q  = 64'd1 << 23;
                ee = ee + 1;
            end
            field = (q >= (64'd1 << 23)) ? ee : 0;
            if (field >= 255) begin
                rz = {s, 8'hFF, 23'd0};
                ro = 1;
            end else begin
                rz = {s, 8'(field), q[22:0]};
                ru = (e < 1) && (inexact || (q == 0));
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input int hold, input string tag);
        logic [31:0] ez;
        logic eo, eu, ei;
        bit sp;
        int lat;
        ref_mul(ta, tb_v, ez, eo, eu, ei, sp);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), sp ? 32'd1 : 32'd27);
        chk({tag, ".z"}, z, ez);
        chk({tag, ".ovf"}, 32'(overflow_flag), 32'(eo));
        chk({tag, ".unf"}, 32'(underflow_flag), 32'(eu));
        chk({tag, ".inv"}, 32'(invalid_flag), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            chk({tag, ".hold_z"}, z, ez);
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".rdy_rise"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] mk_fp(input int e);
        logic s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, 8'(e), m};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int ex, kind;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst.z", z, 32'd0);
        chk("rst.flags", {29'd0, overflow_flag, underflow_flag, invalid_flag},
            32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        run_op(32'h3FC0_0000, 32'h4000_0000, 0, "mul1p5x2");
        run_op(32'h7F00_0000, 32'h7F00_0000, 0, "overflow");
        run_op(32'h0080_0000, 32'h3F00_0000, 0, "denorm_exact");
        run_op(32'h0080_0001, 32'h3F00_0000, 0, "denorm_tie");
        run_op(32'h7F80_0000, 32'h0000_0000, 0, "inf_x_zero");
        run_op(32'hFF80_0000, 32'h4000_0000, 0, "neg_inf");
        run_op(32'h7FC0_1234, 32'h3F80_0000, 0, "nan_op");
        run_op(32'h8000_0000, 32'h4000_0000, 0, "neg_zero");
        run_op(32'h3F80_0001, 32'h3F80_0001, 10, "sticky_hold");
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 0, "carry_out");

        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h4040_0000;
        b = 32'h4040_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h4040_0000, 32'hC080_0000, 0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    ra = mk_fp($urandom_range(100, 154));
                    rb = mk_fp($urandom_range(100, 154));
                end
                1: begin
                    ex = $urandom_range(1, 126);
                    ra = mk_fp(ex);
                    rb = mk_fp(101 - ex + $urandom_range(0, 28));
                end
                2: begin
                    ex = $urandom_range(127, 254);
                    ra = mk_fp(ex);
                    rb = mk_fp(377 - ex + $urandom_range(0, 6));
                end
                default: begin
                    ra = $urandom;
                    rb = $urandom;
                end
            endcase
            run_op(ra, rb, 0, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
